hello_multi: RTL and testbench

Parametrised, multi-channel successor to the single-bit `hello` cell. Each of `CH` asynchronous inputs passes through a synchronizer and a debouncer. The clean level then drives a per-channel output whose behaviour is set by a runtime mode: pass, invert, toggle or freeze. Each channel also produces registered rise/fall pulses and a saturating rising-edge counter. The block sits between raw board inputs (switches, buttons) and the logic that consumes them.

---
 rtl/hello_multi.sv | 70 +++++++
 tb/tb_hello_multi.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hello_multi.sv
// hello_multi: per-channel synchronizer, debouncer, mode-controlled output,
// registered rise/fall pulses and saturating rising-edge counters.
module hello_multi #(
   parameter int CH     = 4,
   parameter int STABLE = 8,
   parameter int CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CH-1:0]       a,
   input  logic [1:0]          mode,
   input  logic                clr,
   output logic [CH-1:0]       b,
   output logic [CH-1:0]       rise,
   output logic [CH-1:0]       fall,
   output logic [CH*CNT_W-1:0] count
);
   localparam int DW = $clog2(STABLE) + 1;
   localparam logic [DW-1:0] LAST = DW'(STABLE - 1);
   logic [CH-1:0] s1_q, s2_q, db_q, db_d, b_q, b_d, rise_q, rise_d, fall_q, fall_d;
   logic [DW-1:0] cnt_q [CH];
   logic [DW-1:0] cnt_d [CH];
   logic [CH*CNT_W-1:0] count_q, count_d;
   always_comb begin
      db_d    = db_q;
      cnt_d   = cnt_q;
      b_d     = b_q;
      count_d = count_q;
      for (int j = 0; j < CH; j++) begin
         // any agreement, or acceptance, restarts the stability window
         cnt_d[j] = (s2_q[j] == db_q[j] || cnt_q[j] == LAST) ? '0 : cnt_q[j] + 1'b1;
         db_d[j]  = (s2_q[j] != db_q[j] && cnt_q[j] == LAST) ? s2_q[j] : db_q[j];
      end
      rise_d = db_d & ~db_q;
      fall_d = ~db_d & db_q;
      for (int j = 0; j < CH; j++) begin
         b_d[j] = (mode == 2'b00) ? db_d[j] :
                  (mode == 2'b01) ? ~db_d[j] :
                  (mode == 2'b10) ? b_q[j] ^ rise_d[j] : b_q[j];
         count_d[j*CNT_W +: CNT_W] = clr ? '0 :
            (rise_d[j] && count_q[j*CNT_W +: CNT_W] != '1) ? count_q[j*CNT_W +: CNT_W] + 1'b1 :
            count_q[j*CNT_W +: CNT_W];
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         db_q    <= '0;
         cnt_q   <= '{default: '0};
         b_q     <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         count_q <= '0;
      end else begin
         s1_q    <= a;
         s2_q    <= s1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         b_q     <= b_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         count_q <= count_d;
      end
   end
   assign b     = b_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
   assign count = count_q;
endmodule

// File: tb/tb_hello_multi.sv
// tb_hello_multi: directed stimulus with rise/fall pulse scoreboards.
module tb_hello_multi;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  a;
   logic [1:0]  mode;
   logic        clr;
   logic [3:0]  b, rise, fall;
   logic [31:0] count;
   int checks = 0;
   int failures = 0;
   logic [3:0] rq [$];
   logic [3:0] fq [$];

   hello_multi #(.CH(4), .STABLE(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .a(a), .mode(mode), .clr(clr),
      .b(b), .rise(rise), .fall(fall), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int ch, input int len, input int gap);
      a[ch] = 1'b1;
      if (len >= 8) begin
         rq.push_back(4'(1 << ch));
         fq.push_back(4'(1 << ch));
      end
      tick(len);
      a[ch] = 1'b0;
      tick(gap);
   endtask

   // pulses popped in order as the DUT emits them
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (rise !== 4'h0) begin
            if (rq.size() == 0) chk("rise_unexpected", 32'(rise), 32'h0);
            else chk("rise_seq", 32'(rise), 32'(rq.pop_front()));
         end
         if (fall !== 4'h0) begin
            if (fq.size() == 0) chk("fall_unexpected", 32'(fall), 32'h0);
            else chk("fall_seq", 32'(fall), 32'(fq.pop_front()));
         end
      end
   end

   initial begin
      a = 4'hF; mode = 2'b00; clr = 1'b0; rst = 1'b0;
      #1 rst = 1'b1;
      tick(3);
      chk("rst_b", 32'(b), 32'h0);
      chk("rst_rise", 32'(rise), 32'h0);
      chk("rst_count", count, 32'h0);
      rst = 1'b0;
      rq.push_back(4'hF);
      tick(9);
      chk("lat_rise_early", 32'(rise), 32'h0);
      chk("lat_b_early", 32'(b), 32'h0);
      tick(1);
      chk("lat_rise", 32'(rise), 32'hF);
      chk("lat_b", 32'(b), 32'hF);
      chk("lat_count", count, 32'h01010101);
      tick(1);
      chk("lat_rise_once", 32'(rise), 32'h0);
      a = 4'h0;
      fq.push_back(4'hF);
      tick(12);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      chk("clr_all", count, 32'h0);

      a[0] = 1'b1;
      tick(7);
      a[0] = 1'b0;
      tick(12);
      chk("glitch7_b", 32'(b), 32'h0);
      chk("glitch7_count", count, 32'h0);
      a[0] = 1'b1;
      rq.push_back(4'h1);
      tick(8);
      a[0] = 1'b0;
      tick(2);
      chk("accept8_b", 32'(b), 32'h1);
      fq.push_back(4'h1);
      tick(12);
      chk("accept8_b_low", 32'(b), 32'h0);
      chk("accept8_count", count, 32'h00000001);

      mode = 2'b10;
      for (int p = 0; p < 3; p++) begin
         a[1] = 1'b1;
         rq.push_back(4'h2);
         fq.push_back(4'h2);
         tick(10);
         chk("tog_after_rise", 32'(b[1]), 32'(p % 2 == 0));
         tick(10);
         a[1] = 1'b0;
         tick(10);
         chk("tog_after_fall", 32'(b[1]), 32'(p % 2 == 0));
         tick(10);
      end
      chk("tog_b", 32'(b), 32'h2);
      chk("tog_count", count, 32'h00000301);

      mode = 2'b01;
      tick(1);
      chk("inv_b", 32'(b), 32'hF);
      mode = 2'b11;
      pulse(2, 20, 20);
      pulse(2, 20, 20);
      chk("frz_b", 32'(b), 32'hF);
      chk("frz_count", count, 32'h00020301);

      mode = 2'b00;
      tick(1);
      chk("pass_b", 32'(b), 32'h0);
      for (int p = 0; p < 300; p++) pulse(3, 10, 10);
      chk("sat_count", count, 32'hFF020301);
      a[3] = 1'b1;
      rq.push_back(4'h8);
      tick(9);
      clr = 1'b1;
      tick(1);
      chk("clr_rise", 32'(rise), 32'h8);
      chk("clr_wins", count, 32'h0);
      clr = 1'b0;
      a[3] = 1'b0;
      fq.push_back(4'h8);
      tick(12);
      pulse(3, 10, 12);
      chk("post_clr_count", count, 32'h01000000);

      a[0] = 1'b1;
      tick(5);
      rst = 1'b1;
      tick(2);
      chk("mid_rst_b", 32'(b), 32'h0);
      chk("mid_rst_rise", 32'(rise), 32'h0);
      chk("mid_rst_fall", 32'(fall), 32'h0);
      chk("mid_rst_count", count, 32'h0);
      rst = 1'b0;
      rq.push_back(4'h1);
      tick(9);
      chk("relat_rise_early", 32'(rise), 32'h0);
      tick(1);
      chk("relat_rise", 32'(rise), 32'h1);
      chk("relat_b", 32'(b), 32'h1);
      chk("relat_count", count, 32'h00000001);
      a[0] = 1'b0;
      fq.push_back(4'h1);
      tick(12);
      chk("rq_drained", 32'(rq.size()), 32'h0);
      chk("fq_drained", 32'(fq.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
